// File: rtl/if_stage_pkg.sv
// Shared widths, reset constant and the IF/ID slot bundle
// for the instruction-fetch stage.
package if_stage_pkg;

    localparam int REG_BUS  = 64;
    localparam int INST_BUS = 32;

    typedef logic [REG_BUS-1:0]  reg_t;
    typedef logic [INST_BUS-1:0] inst_t;

    localparam reg_t RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam reg_t PC_STEP      = 64'd4;

    typedef struct packed {
        logic  valid;
        reg_t  pc;
        inst_t inst;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction bus between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic  inst_req_valid;
    logic  inst_req_ready;
    reg_t  inst_req_addr;
    logic  inst_resp_valid;
    inst_t inst_resp_data;

    modport master (
        output inst_req_valid,
        output inst_req_addr,
        input  inst_req_ready,
        input  inst_resp_valid,
        input  inst_resp_data
    );

    modport slave (
        input  inst_req_valid,
        input  inst_req_addr,
        output inst_req_ready,
        output inst_resp_valid,
        output inst_resp_data
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one bus read
// in flight and fills the IF/ID slot; EX redirects squash the path.
module if_stage
    import if_stage_pkg::*;
#(
    parameter reg_t RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  reg_t              redirect_pc,
    input  logic              stall,
    if_stage_if.master        bus,
    output logic              if_valid,
    output reg_t              if_pc,
    output inst_t             if_inst
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] KILL = 2'd2;

    logic [1:0] state_q, state_d;
    reg_t       pc_q, pc_d;
    reg_t       req_pc_q, req_pc_d;
    if_id_t     slot_q, slot_d;

    logic slot_free;
    logic req_fire;
    logic resp;
    logic load;

    assign slot_free = !slot_q.valid || !stall;
    assign req_fire  = bus.inst_req_valid && bus.inst_req_ready;
    assign resp      = bus.inst_resp_valid;
    assign load      = (state_q == WAIT) && resp && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // A response always ends the in-flight read, squashed or not.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ: begin
                if (req_fire) begin
                    state_d = redirect_valid ? KILL : WAIT;
                end
            end
            WAIT: begin
                if (resp) begin
                    state_d = REQ;
                end else if (redirect_valid) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (resp) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        bus.inst_req_valid = (state_q == REQ) && slot_free;
        bus.inst_req_addr  = pc_q;
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        slot_d   = slot_q;
        if (req_fire) begin
            req_pc_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            slot_d.valid = 1'b0;
        end else if (load) begin
            pc_d        = req_pc_q + PC_STEP;
            slot_d.valid = 1'b1;
            slot_d.pc    = req_pc_q;
            slot_d.inst  = bus.inst_resp_data;
        end else if (!stall) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            slot_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            slot_q   <= slot_d;
        end
    end

    assign if_valid = slot_q.valid;
    assign if_pc    = slot_q.pc;
    assign if_inst  = slot_q.inst;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV64 five-stage pipeline. It owns the architectural fetch PC and issues one instruction read at a time on the instruction bus. It registers the returned 32-bit instruction into the IF/ID output slot. It is the consumer of the execute stage's branch/jump outcome: a redirect updates the PC and discards any fetch in flight.

## Interface

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  taken branch or jump resolved in EX this cycle
- redirect_pc  in  64  target PC (bit 0 already cleared by EX)
- stall  in  1  ID cannot accept; hold IF/ID slot
- inst_req_valid  out  1  fetch request
- inst_req_ready  in  1  bus accepts request
- inst_req_addr  out  64  fetch address
- inst_resp_valid  in  1  instruction data returned
- inst_resp_data  in  32  instruction word
- if_valid  out  1  IF/ID slot holds a valid instruction
- if_pc  out  64  PC of if_inst
- if_inst  out  32  fetched instruction

## Operation

- Registers:
  - pc_q, the next fetch address.
  - req_pc_q, the address of the outstanding fetch.
  - The output slot (if_valid, if_pc, if_inst).
  - A 2-bit state.
- Request stickiness: a request is taken only on inst_req_valid & inst_req_ready. While unaccepted, inst_req_addr may change on redirect.
- Exactly one request is outstanding at a time. Responses arrive in order, at the earliest one cycle after acceptance.
- Slot free: slot_free = !if_valid || !stall.
- inst_req_valid = (state==REQ) && slot_free. inst_req_addr = pc_q.
- States:
  - REQ: on a request handshake, req_pc_q <= pc_q, then go to WAIT.
  - WAIT: on inst_resp_valid, load the slot, pc_q <= req_pc_q + 4, then go to REQ.
  - KILL: the outstanding response belongs to a squashed path. On inst_resp_valid, discard the data, then go to REQ.
- Redirect has priority over every other event, including stall. It takes effect at the clock edge ending the cycle in which it is asserted.
  - It always sets pc_q <= redirect_pc and clears if_valid.
  - In REQ, with or without a handshake in the same cycle: if a handshake occurs, go to KILL; otherwise stay in REQ.
  - In WAIT without a response: go to KILL.
  - In WAIT with a response in the same cycle: discard the response and go to REQ.
  - In KILL: stay in KILL. If the response arrives in the same cycle, go to REQ instead.
- Output slot without a redirect:
  - A slot load sets if_valid=1, if_pc=req_pc_q and if_inst=inst_resp_data.
  - Otherwise, if !stall, if_valid <= 0.
  - if_pc and if_inst hold their values when the slot is not loaded.
- A request is issued only when the slot is free, so a response never meets an occupied, stalled slot.
- PC arithmetic is a 64-bit wrap-around add of 4; there is no overflow detection.
- Misaligned redirect_pc is passed through unchanged.

## Timing

- Reset (asynchronous, rst=0):
  - state=REQ, pc_q=RESET_PC, req_pc_q=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - inst_req_valid=1 in the first cycle after release.
- Latency: handshake in cycle N, response in cycle N+k (k≥1), if_valid high in cycle N+k+1.
- Throughput: one instruction per two cycles with a 1-cycle bus.
- Redirect in cycle N: the request for redirect_pc appears in cycle N+1 if the state is REQ. Otherwise it appears one cycle after the squashed response.
- Reset asserted mid-WAIT: the pending response is forgotten. The bus side must be reset from the same rst.

## Structure

- Shared defines file:
  - Use the existing REG_BUS.
  - Add INST_BUS (31:0) and a RESET_PC default constant.
- State encodings are local parameters (REQ, WAIT, KILL).
- Single module; no sub-module needed. The +4 is a plain adder.

## Test plan

- Reset, ready=1, 1-cycle response: requests to 0x80000000, 0x80000004, 0x80000008. Each if_pc/if_inst pair appears two cycles after its request.
- stall held 3 cycles while if_valid=1: if_pc and if_inst stay constant and no request is issued. The request to the next PC is issued in the same cycle stall drops.
- Redirect to 0x80001000 while in WAIT, response 2 cycles later: that response is discarded (if_valid stays 0). The next request goes to 0x80001000.
- Redirect in the same cycle as the response: the response is dropped, if_valid=0, and the next request goes to the target.
- Redirect while in REQ with inst_req_ready=0: inst_req_addr changes to the target the next cycle, and no squashed data ever reaches the slot.
- Redirect with stall=1 and if_valid=1: if_valid clears at the next edge. rst pulsed mid-WAIT restarts fetch at RESET_PC.
